// File: rtl/pong_pkg.sv
// pong_pkg: shared state encodings, serve directions and winner codes for the Pong match sequencer
package pong_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;
  localparam logic SERVE_RIGHT = 1'b0;
  localparam logic SERVE_LEFT  = 1'b1;
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: 8-bit frame down-counter, done on the tick that finds it at zero
module pong_frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       tick,
  input  logic [7:0] value,
  output logic       done
);
  logic [7:0] cnt;
  assign done = tick & (cnt == 8'd0);
  always_ff @(posedge clk) begin
    if (rst) cnt <= 8'd0;
    else if (load) cnt <= value;
    else if (tick && cnt != 8'd0) cnt <= cnt - 8'd1;
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer gating ball/paddles, serving, scoring and declaring a winner
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE    = 4'd10,
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] POINT_FRAMES = 8'd30,
  parameter logic [7:0] BLINK_FRAMES = 8'd15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic [3:0] i_score1,
  input  logic [3:0] i_score2,
  output logic       o_ball_reset,
  output logic       o_ball_run,
  output logic       o_serve_dir,
  output logic       o_paddle_en,
  output logic [2:0] o_state,
  output logic [1:0] o_winner,
  output logic       o_blink
);
  state_t state, state_n;
  logic start_q, start_rise, restart, scored, done, load;
  logic [3:0] copy1, copy2;
  logic [7:0] load_val;
  assign start_rise = i_start & ~start_q;
  assign restart = start_rise & (state == ST_IDLE || state == ST_OVER);
  assign scored = (i_score1 != copy1) | (i_score2 != copy2);
  // timer loaded with N-1 so the N-th tick after entry is the one that ends the wait
  assign load = (state_n != state) | (state == ST_OVER && done);
  assign load_val = state_n == ST_SERVE ? SERVE_FRAMES - 8'd1 :
                    state_n == ST_POINT ? POINT_FRAMES - 8'd1 : BLINK_FRAMES - 8'd1;
  assign o_state = state;
  pong_frame_timer u_timer (
    .clk(i_clk), .rst(i_reset), .load(load), .tick(i_frame_tick), .value(load_val), .done(done)
  );
  always_comb begin
    state_n = ST_IDLE;
    case (state)
      ST_IDLE:  state_n = start_rise ? ST_SERVE : ST_IDLE;
      ST_SERVE: state_n = done ? ST_PLAY : ST_SERVE;
      ST_PLAY:  state_n = scored ? ST_POINT : ST_PLAY;
      ST_POINT: state_n = !done ? ST_POINT :
                          (copy1 >= WIN_SCORE || copy2 >= WIN_SCORE) ? ST_OVER : ST_SERVE;
      ST_OVER:  state_n = start_rise ? ST_SERVE : ST_OVER;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      start_q      <= 1'b0;
      copy1        <= 4'd0;
      copy2        <= 4'd0;
      o_ball_reset <= 1'b0;
      o_ball_run   <= 1'b0;
      o_serve_dir  <= SERVE_RIGHT;
      o_paddle_en  <= 1'b0;
      o_winner     <= WINNER_NONE;
      o_blink      <= 1'b0;
    end else begin
      state        <= state_n;
      start_q      <= i_start;
      o_ball_reset <= restart;
      o_ball_run   <= state_n == ST_PLAY;
      o_paddle_en  <= state_n == ST_SERVE || state_n == ST_PLAY || state_n == ST_POINT;
      if (restart) begin
        copy1       <= 4'd0;
        copy2       <= 4'd0;
        o_serve_dir <= SERVE_RIGHT;
        o_winner    <= WINNER_NONE;
        o_blink     <= 1'b0;
      end else if (state == ST_PLAY && scored) begin
        copy1       <= i_score1;
        copy2       <= i_score2;
        o_serve_dir <= (i_score1 != copy1) ? SERVE_LEFT : SERVE_RIGHT;
      end else if (state == ST_POINT && done) begin
        o_winner <= copy1 >= WIN_SCORE ? WINNER_P1 : copy2 >= WIN_SCORE ? WINNER_P2 : WINNER_NONE;
      end else if (state == ST_OVER && done) begin
        o_blink <= ~o_blink;
      end
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for the Pong match sequencer
module tb_pong_game_ctrl;
  logic clk = 1'b0, i_reset, i_frame_tick, i_start;
  logic [3:0] i_score1, i_score2;
  logic o_ball_reset, o_ball_run, o_serve_dir, o_paddle_en, o_blink;
  logic [2:0] o_state;
  logic [1:0] o_winner;
  logic [31:0] snap;
  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sb[$];
  int tests = 0, fails = 0;
  pong_game_ctrl dut (
    .i_clk(clk), .i_reset(i_reset), .i_frame_tick(i_frame_tick), .i_start(i_start),
    .i_score1(i_score1), .i_score2(i_score2), .o_ball_reset(o_ball_reset), .o_ball_run(o_ball_run),
    .o_serve_dir(o_serve_dir), .o_paddle_en(o_paddle_en), .o_state(o_state),
    .o_winner(o_winner), .o_blink(o_blink)
  );
  always #5 clk = ~clk;
  assign snap = {22'd0, o_state, o_winner, o_blink, o_paddle_en, o_serve_dir, o_ball_run, o_ball_reset};
  function automatic logic [31:0] v(input logic [2:0] st, input logic [1:0] win,
      input logic blink, pad, dir, run, br);
    return {22'd0, st, win, blink, pad, dir, run, br};
  endfunction
  task automatic step();
    @(negedge clk);
  endtask
  task automatic push(input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
  endtask
  task automatic check(input logic [31:0] obs);
    sb_t it;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
      end
    end
  endtask
  task automatic one_tick();
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    step();
  endtask
  task automatic ticks_until_state(input logic [2:0] st, output int n);
    n = 0;
    while (o_state !== st && n < 200) begin
      one_tick();
      n++;
    end
  endtask
  task automatic ticks_until_blink(input logic b, output int n);
    n = 0;
    while (o_blink !== b && n < 200) begin
      one_tick();
      n++;
    end
  endtask
  initial begin
    int n, pulses;
    i_reset = 1'b1; i_frame_tick = 1'b0; i_start = 1'b0; i_score1 = 4'd0; i_score2 = 4'd0;
    repeat (3) step();
    push("reset_state", v(3'd0, 2'b00, 0, 0, 0, 0, 0));
    check(snap);
    i_reset = 1'b0;
    step();
    i_start = 1'b1;
    push("start_pulse", v(3'd1, 2'b00, 0, 1, 0, 0, 1));
    step();
    check(snap);
    i_start = 1'b0;
    push("reset_one_cycle", v(3'd1, 2'b00, 0, 1, 0, 0, 0));
    step();
    check(snap);
    ticks_until_state(3'd2, n);
    push("serve_ticks", 32'd60);
    check(32'(n));
    push("play_entry", v(3'd2, 2'b00, 0, 1, 0, 1, 0));
    check(snap);
    i_score2 = 4'd1;
    push("p2_point", v(3'd3, 2'b00, 0, 1, 0, 0, 0));
    step();
    check(snap);
    ticks_until_state(3'd1, n);
    push("point_ticks", 32'd30);
    check(32'(n));
    push("reserve_right", v(3'd1, 2'b00, 0, 1, 0, 0, 0));
    check(snap);
    ticks_until_state(3'd2, n);
    i_score1 = 4'd1;
    i_score2 = 4'd2;
    push("both_point", v(3'd3, 2'b00, 0, 1, 1, 0, 0));
    step();
    check(snap);
    push("no_double_entry", v(3'd3, 2'b00, 0, 1, 1, 0, 0));
    step();
    check(snap);
    ticks_until_state(3'd1, n);
    push("both_point_ticks", 32'd30);
    check(32'(n));
    ticks_until_state(3'd2, n);
    i_score1 = 4'd10;
    push("win_point", v(3'd3, 2'b00, 0, 1, 1, 0, 0));
    step();
    check(snap);
    ticks_until_state(3'd4, n);
    push("over_ticks", 32'd30);
    check(32'(n));
    push("over_entry", v(3'd4, 2'b01, 0, 0, 1, 0, 0));
    check(snap);
    ticks_until_blink(1'b1, n);
    push("blink_on_ticks", 32'd15);
    check(32'(n));
    ticks_until_blink(1'b0, n);
    push("blink_off_ticks", 32'd15);
    check(32'(n));
    i_start = 1'b1;
    push("restart_from_over", v(3'd1, 2'b00, 0, 1, 0, 0, 1));
    step();
    check(snap);
    i_start = 1'b0;
    i_score1 = 4'd0;
    i_score2 = 4'd0;
    step();
    ticks_until_state(3'd2, n);
    push("restart_serve_ticks", 32'd60);
    check(32'(n));
    i_start = 1'b1;
    push("start_in_play", v(3'd2, 2'b00, 0, 1, 0, 1, 0));
    step();
    check(snap);
    i_start = 1'b0;
    push("start_in_play_after", v(3'd2, 2'b00, 0, 1, 0, 1, 0));
    step();
    check(snap);
    i_score2 = 4'd1;
    step();
    repeat (5) one_tick();
    i_reset = 1'b1;
    push("reset_mid_point", v(3'd0, 2'b00, 0, 0, 0, 0, 0));
    step();
    check(snap);
    i_reset = 1'b0;
    step();
    i_start = 1'b1;
    pulses = 0;
    repeat (500) begin
      step();
      pulses += int'(o_ball_reset);
    end
    push("held_start_pulses", 32'd1);
    check(32'(pulses));
    push("held_start_state", v(3'd1, 2'b00, 0, 1, 0, 0, 0));
    check(snap);
    i_start = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
